dcache_port_responder: RTL and testbench



---
 rtl/dcache_port_resp_pkg.sv | 37 +++
 rtl/dcache_port_mem.sv | 50 +++++
 rtl/dcache_port_responder.sv | 115 +++++++++++
 tb/tb_dcache_port_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_resp_pkg.sv
// Shared types and constants for the dcache port responder.
// Port structs are field-compatible with the ariane_pkg dcache request port.
package dcache_port_resp_pkg;

  localparam int unsigned DcacheIndexWidth = 12;
  localparam int unsigned DcacheTagWidth   = 44;
  localparam int unsigned PlenWidth        = DcacheIndexWidth + DcacheTagWidth;

  // Stall LFSR: x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left
  localparam logic [7:0] LfsrSeed = 8'hA5;
  localparam logic [7:0] LfsrTaps = 8'hB8;

  typedef struct packed {
    logic [DcacheIndexWidth-1:0] address_index;
    logic [DcacheTagWidth-1:0]   address_tag;
    logic [63:0]                 data_wdata;
    logic                        data_req;
    logic                        data_we;
    logic [7:0]                  data_be;
    logic [1:0]                  data_size;
    logic                        kill_req;
    logic                        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitTag,
    StResp
  } resp_state_e;

endpackage

// File: rtl/dcache_port_mem.sv
// NumWords x 64-bit memory with byte-enable write and registered (synchronous) read.
// InitZero selects whether the array is cleared on reset.
module dcache_port_mem #(
  parameter int unsigned NumWords  = 1024,
  parameter bit          InitZero  = 1'b1,
  localparam int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [63:0]          wdata,
  input  logic [7:0]           be,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output logic [63:0]          rdata
);

  logic [63:0] mem_q [NumWords];

  if (InitZero) begin : g_init_zero
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
      end else if (we) begin
        for (int b = 0; b < 8; b++) begin
          if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end else begin : g_no_init
    always_ff @(posedge clk) begin
      if (we) begin
        for (int b = 0; b < 8; b++) begin
          if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register only updates on a read, so the output holds between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/dcache_port_responder.sv
// Scratchpad responder for the dcache request port: grants, late tag capture, read data.
// Optional macro DCACHE_PORT_RESP_STALL_EN adds LFSR-driven pseudo-random grant stalls.
module dcache_port_responder
  import dcache_port_resp_pkg::*;
#(
  parameter int unsigned NumWords = 1024,
  parameter bit          InitZero = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dcache_req_i_t req_i,
  output dcache_req_o_t req_o,
  output logic          busy_o
);

  localparam int unsigned AddrWidth = $clog2(NumWords);

  resp_state_e                 state_q, state_d;
  logic [DcacheIndexWidth-1:0] idx_q, idx_d;
  logic                        stall;
  logic                        accept;
  logic                        mem_we;
  logic                        mem_re;
  logic [63:0]                 mem_rdata;
  logic [PlenWidth-1:0]        wr_pa;
  logic [PlenWidth-1:0]        rd_pa;
  logic                        unused_bits;

`ifdef DCACHE_PORT_RESP_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Writes carry the full address up front; reads pair the late tag with the held index
  assign wr_pa = {req_i.address_tag, req_i.address_index};
  assign rd_pa = {req_i.address_tag, idx_q};

  assign unused_bits = ^{wr_pa, rd_pa, req_i.data_size};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        accept  = req_i.data_req & ~stall;
        state_d = StIdle;
        if (accept) begin
          if (req_i.data_we) begin
            mem_we = 1'b1;
          end else begin
            idx_d   = req_i.address_index;
            state_d = StWaitTag;
          end
        end
      end
      StWaitTag: begin
        if (req_i.kill_req) begin
          state_d = StIdle;
        end else if (req_i.tag_valid) begin
          mem_re  = 1'b1;
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  dcache_port_mem #(
    .NumWords (NumWords),
    .InitZero (InitZero)
  ) u_mem (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (mem_we),
    .waddr (wr_pa[AddrWidth+2:3]),
    .wdata (req_i.data_wdata),
    .be    (req_i.data_be),
    .re    (mem_re),
    .raddr (rd_pa[AddrWidth+2:3]),
    .rdata (mem_rdata)
  );

  always_comb begin
    req_o             = '0;
    req_o.data_gnt    = accept & ~rst_i;
    req_o.data_rvalid = (state_q == StResp);
    req_o.data_rdata  = mem_rdata;
    busy_o            = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dcache_port_responder.sv
// Self-checking bench for dcache_port_responder: directed scenarios plus randomized traffic
// checked against a word-level memory model.
module tb_dcache_port_responder;
  import dcache_port_resp_pkg::*;

  localparam int unsigned NumWords = 1024;
  localparam int unsigned AW       = $clog2(NumWords);

  logic          clk;
  logic          rst;
  dcache_req_i_t req;
  dcache_req_o_t rsp;
  logic          busy;

  int n_cmp;
  int n_err;

  logic [63:0] model_mem [int];

  dcache_port_responder #(
    .NumWords (NumWords),
    .InitZero (1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .req_o  (rsp),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int widx(input logic [55:0] pa);
    return int'(pa[AW+2:3]);
  endfunction

  function automatic logic [63:0] model_read(input logic [55:0] pa);
    if (model_mem.exists(widx(pa))) return model_mem[widx(pa)];
    return 64'h0;
  endfunction

  function automatic void model_write(input logic [55:0] pa, input logic [63:0] wd,
                                      input logic [7:0] be);
    logic [63:0] w;
    w = model_read(pa);
    for (int b = 0; b < 8; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    model_mem[widx(pa)] = w;
  endfunction

  function automatic logic [55:0] rand_pa();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[55:0];
  endfunction

  // Drives one write in the next cycle; inputs stay asserted until the next task drives.
  task automatic write_txn(input logic [55:0] pa, input logic [63:0] wd, input logic [7:0] be,
                           output logic gnt);
    @(negedge clk);
    req               = '0;
    req.data_req      = 1'b1;
    req.data_we       = 1'b1;
    req.address_index = pa[11:0];
    req.address_tag   = pa[55:12];
    req.data_wdata    = wd;
    req.data_be       = be;
    req.data_size     = 2'b11;
    #1 gnt = rsp.data_gnt;
    if (gnt === 1'b1) model_write(pa, wd, be);
  endtask

  // Read: grant cycle, `delay` tagless cycles, tag cycle, then sample the response cycle.
  task automatic read_txn(input logic [55:0] pa, input int delay, input bit kill,
                          output logic gnt0, output bit waits_ok, output logic rv,
                          output logic [63:0] data, output logic busy_after);
    logic [63:0] junk;
    @(negedge clk);
    junk              = {$urandom, $urandom};
    req               = '0;
    req.data_req      = 1'b1;
    req.address_index = pa[11:0];
    req.address_tag   = junk[43:0];
    #1 gnt0 = rsp.data_gnt;
    waits_ok = 1'b1;
    repeat (delay) begin
      @(negedge clk);
      junk            = {$urandom, $urandom};
      req             = '0;
      req.address_tag = junk[43:0];
      #1 if (rsp.data_gnt !== 1'b0 || busy !== 1'b1 || rsp.data_rvalid !== 1'b0) waits_ok = 1'b0;
    end
    @(negedge clk);
    req             = '0;
    req.address_tag = pa[55:12];
    req.kill_req    = kill;
    req.tag_valid   = kill ? 1'($urandom_range(0, 1)) : 1'b1;
    #1 if (rsp.data_gnt !== 1'b0 || busy !== 1'b1) waits_ok = 1'b0;
    @(negedge clk);
    req = '0;
    #1;
    rv         = rsp.data_rvalid;
    data       = rsp.data_rdata;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    req          = '0;
    req.data_req = 1'b1;
    #12;
    n_cmp++;
    if ({rsp.data_gnt, rsp.data_rvalid, busy} !== 3'b000 || rsp.data_rdata !== 64'h0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b busy=%b rdata=%h, need all 0",
               rsp.data_gnt, rsp.data_rvalid, busy, rsp.data_rdata);
    end
    @(negedge clk);
    req = '0;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic gnt, g0, rv, ba;
    bit wok;
    logic [63:0] d;
    write_txn(56'h100, 64'h1122334455667788, 8'hFF, gnt);
    n_cmp++;
    if (gnt !== 1'b1) begin
      n_err++;
      $display("FAIL wr_gnt: got %b need 1", gnt);
    end
    read_txn(56'h100, 0, 1'b0, g0, wok, rv, d, ba);
    n_cmp++;
    if (g0 !== 1'b1 || !wok || rv !== 1'b1 || ba !== 1'b1) begin
      n_err++;
      $display("FAIL rd_timing: gnt=%b waits_ok=%0d rvalid=%b busy=%b need 1,1,1,1",
               g0, wok, rv, ba);
    end
    n_cmp++;
    if (d !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL rd_after_wr: got %h need %h", d, 64'h1122334455667788);
    end
    @(negedge clk);
    #1 n_cmp++;
    if (rsp.data_rvalid !== 1'b0 || rsp.data_rdata !== 64'h1122334455667788) begin
      n_err++;
      $display("FAIL rvalid_one_cycle: rvalid=%b rdata=%h need 0 and held data",
               rsp.data_rvalid, rsp.data_rdata);
    end
  endtask

  task automatic test_byte_enable();
    logic gnt, g0, rv, ba;
    bit wok;
    logic [63:0] d;
    write_txn(56'h100, 64'hFFFFFFFF_AAAAAAAA, 8'h0F, gnt);
    read_txn(56'h100, 0, 1'b0, g0, wok, rv, d, ba);
    n_cmp++;
    if (rv !== 1'b1 || d !== 64'h11223344_AAAAAAAA) begin
      n_err++;
      $display("FAIL byte_enable: rvalid=%b got %h need %h", rv, d, 64'h11223344_AAAAAAAA);
    end
  endtask

  task automatic test_delayed_tag();
    logic g0, rv, ba;
    bit wok;
    logic [63:0] d;
    read_txn(56'h100, 5, 1'b0, g0, wok, rv, d, ba);
    n_cmp++;
    if (g0 !== 1'b1 || !wok) begin
      n_err++;
      $display("FAIL delayed_tag_wait: gnt0=%b waits_ok=%0d need 1,1", g0, wok);
    end
    n_cmp++;
    if (rv !== 1'b1 || d !== model_read(56'h100)) begin
      n_err++;
      $display("FAIL delayed_tag_data: rvalid=%b got %h need %h", rv, d, model_read(56'h100));
    end
  endtask

  task automatic test_kill();
    logic g0;
    bit ok;
    @(negedge clk);
    req               = '0;
    req.data_req      = 1'b1;
    req.address_index = 12'h100;
    #1 g0 = rsp.data_gnt;
    @(negedge clk);
    req           = '0;
    req.kill_req  = 1'b1;
    req.tag_valid = 1'b1;
    #1;
    @(negedge clk);
    req               = '0;
    req.data_req      = 1'b1;
    req.address_index = 12'h108;
    #1 ok = (rsp.data_rvalid === 1'b0) && (busy === 1'b0) && (rsp.data_gnt === 1'b1);
    n_cmp++;
    if (g0 !== 1'b1 || !ok) begin
      n_err++;
      $display("FAIL kill: gnt0=%b rvalid=%b busy=%b next_gnt=%b need 1,0,0,1",
               g0, rsp.data_rvalid, busy, rsp.data_gnt);
    end
    @(negedge clk);
    req           = '0;
    req.tag_valid = 1'b1;
    @(negedge clk);
    req = '0;
    #1 n_cmp++;
    if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== model_read(56'h108)) begin
      n_err++;
      $display("FAIL after_kill_read: rvalid=%b got %h need %h",
               rsp.data_rvalid, rsp.data_rdata, model_read(56'h108));
    end
  endtask

  task automatic test_back_to_back();
    logic gnt;
    logic [55:0] rd_list [3];
    int next_rd;
    bit exp_gnt, exp_rv;
    write_txn(56'h0, {$urandom, $urandom}, 8'hFF, gnt);
    write_txn(56'h8, {$urandom, $urandom}, 8'hFF, gnt);
    rd_list[0] = 56'h0;
    rd_list[1] = 56'h8;
    rd_list[2] = 56'h0;
    next_rd    = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req           = '0;
      req.data_req  = (c <= 4);
      req.tag_valid = (c % 2 == 1);
      if (next_rd < 3) req.address_index = rd_list[next_rd][11:0];
      exp_gnt = (c % 2 == 0) && (c <= 4);
      exp_rv  = (c % 2 == 0) && (c >= 2);
      #1 n_cmp++;
      if (rsp.data_gnt !== exp_gnt || rsp.data_rvalid !== exp_rv) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: gnt=%b rvalid=%b need %b %b",
                 c, rsp.data_gnt, rsp.data_rvalid, exp_gnt, exp_rv);
      end
      if (exp_rv) begin
        n_cmp++;
        if (rsp.data_rdata !== model_read(rd_list[(c-2)/2])) begin
          n_err++;
          $display("FAIL b2b_data%0d: got %h need %h",
                   c, rsp.data_rdata, model_read(rd_list[(c-2)/2]));
        end
      end
      if (exp_gnt) next_rd++;
    end
  endtask

  task automatic test_random();
    logic gnt, g0, rv, ba;
    bit wok, kill, bad;
    logic [63:0] d, wd;
    logic [55:0] pa;
    logic [55:0] written [$];
    int delay;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0 || written.size() == 0) begin
        pa = rand_pa();
        wd = {$urandom, $urandom};
        write_txn(pa, wd, 8'($urandom), gnt);
        written.push_back(pa);
        n_cmp++;
        if (gnt !== 1'b1) begin
          n_err++;
          $display("FAIL rand_wr_gnt%0d: got %b need 1", i, gnt);
        end
      end else begin
        pa = written[$urandom_range(0, written.size() - 1)];
        // flip bits above the word index to exercise aliasing
        if ($urandom_range(0, 1) == 1) pa[55:AW+3] = ~pa[55:AW+3];
        delay = $urandom_range(0, 3);
        kill  = ($urandom_range(0, 5) == 0);
        read_txn(pa, delay, kill, g0, wok, rv, d, ba);
        bad = (g0 !== 1'b1) || !wok || (rv !== !kill) || (ba !== !kill);
        if (!kill && d !== model_read(pa)) bad = 1'b1;
        n_cmp++;
        if (bad) begin
          n_err++;
          $display("FAIL rand_rd%0d: pa=%h kill=%0d gnt=%b wok=%0d rv=%b busy=%b got %h need %h",
                   i, pa, kill, g0, wok, rv, ba, d, model_read(pa));
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic g0, rv, ba, gnt;
    bit wok;
    logic [63:0] d;
    write_txn(56'h100, 64'hDEADBEEF_01234567, 8'hFF, gnt);
    read_txn(56'h100, 0, 1'b0, g0, wok, rv, d, ba);
    @(negedge clk);
    req               = '0;
    req.data_req      = 1'b1;
    req.address_index = 12'h100;
    @(negedge clk);
    req              = '0;
    req.data_req     = 1'b1;
    #2 rst = 1'b1;
    #1 n_cmp++;
    if ({rsp.data_gnt, rsp.data_rvalid, busy} !== 3'b000 || rsp.data_rdata !== 64'h0) begin
      n_err++;
      $display("FAIL reset_async: gnt=%b rvalid=%b busy=%b rdata=%h need all 0",
               rsp.data_gnt, rsp.data_rvalid, busy, rsp.data_rdata);
    end
    @(negedge clk);
    rst           = 1'b0;
    req           = '0;
    req.tag_valid = 1'b1;
    @(negedge clk);
    req = '0;
    #1 n_cmp++;
    if (rsp.data_rvalid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drop: rvalid=%b busy=%b need 0 0", rsp.data_rvalid, busy);
    end
    model_mem.delete();
    read_txn(56'h100, 1, 1'b0, g0, wok, rv, d, ba);
    n_cmp++;
    if (rv !== 1'b1 || d !== model_read(56'h100)) begin
      n_err++;
      $display("FAIL reset_cleared: rvalid=%b got %h need %h", rv, d, model_read(56'h100));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = '0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_delayed_tag();
    test_kill();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
